// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data cache memory arbiter.
// State and owner encodings are fixed so caches and memory models can decode them.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 6;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // Round-robin pick: on conflict the requester that did not win last time goes first.
   function automatic owner_t pick_owner(input logic i_req, input logic d_req, input owner_t last);
      owner_t pick;
      if (i_req && d_req) begin
         pick = (last == OWN_I) ? OWN_D : OWN_I;
      end else if (d_req) begin
         pick = OWN_D;
      end else begin
         pick = OWN_I;
      end
      return pick;
   endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Wait-cycle watchdog: counts WAIT cycles and flags the last permitted one.
// The count saturates at the terminal value so a stuck enable cannot wrap it.
module mem_watchdog #(
   parameter  int unsigned TIMEOUT = 255,
   localparam int unsigned CNT_W   = $clog2(TIMEOUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             tc_c
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (en && !tc_c) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign tc_c = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-memory port between the icache (read-only) and dcache (read/write).
// Round-robin on conflict; each access runs IDLE -> ISSUE -> WAIT -> DONE.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              I_READ,
   input  logic [ADDR_W-1:0] I_ADDRESS,
   output logic [DATA_W-1:0] I_READDATA,
   output logic              I_BUSYWAIT,
   input  logic              D_READ,
   input  logic              D_WRITE,
   input  logic [ADDR_W-1:0] D_ADDRESS,
   input  logic [DATA_W-1:0] D_WRITEDATA,
   output logic [DATA_W-1:0] D_READDATA,
   output logic              D_BUSYWAIT,
   output logic              M_READ,
   output logic              M_WRITE,
   output logic [ADDR_W-1:0] M_ADDRESS,
   output logic [DATA_W-1:0] M_WRITEDATA,
   input  logic [DATA_W-1:0] M_READDATA,
   input  logic              M_BUSYWAIT,
   output logic              ERR
);

   state_t state_q, state_d;
   owner_t owner_q, last_q, grant_owner_c;
   logic   write_q;
   logic   i_req_c, d_req_c;
   logic   grant_c, finish_c, capture_c, timeout_c;
   logic   wd_clr_c, wd_en_c, wd_tc_c;

   assign i_req_c       = I_READ;
   assign d_req_c       = D_READ | D_WRITE;
   assign grant_owner_c = pick_owner(i_req_c, d_req_c, last_q);

   // Stall releases only in the DONE cycle of the requester's own access.
   assign I_BUSYWAIT = i_req_c & ~((state_q == ST_DONE) && (owner_q == OWN_I));
   assign D_BUSYWAIT = d_req_c & ~((state_q == ST_DONE) && (owner_q == OWN_D));

   mem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (CLK),
      .rst_n    (RESET),
      .clr      (wd_clr_c),
      .load     (1'b0),
      .load_val ('0),
      .en       (wd_en_c),
      .tc_c     (wd_tc_c)
   );

   // Next-state and per-cycle control decisions.
   always_comb begin
      state_d   = state_q;
      grant_c   = 1'b0;
      finish_c  = 1'b0;
      capture_c = 1'b0;
      timeout_c = 1'b0;
      wd_clr_c  = 1'b0;
      wd_en_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_req_c || d_req_c) begin
               grant_c = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wd_clr_c = 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            wd_en_c = 1'b1;
            if (!M_BUSYWAIT) begin
               finish_c  = 1'b1;
               capture_c = ~write_q;
               state_d   = ST_DONE;
            end else if (wd_tc_c) begin
               finish_c  = 1'b1;
               timeout_c = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, latched request and registered memory/cache outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_I;
         last_q      <= OWN_I;
         write_q     <= 1'b0;
         M_READ      <= 1'b0;
         M_WRITE     <= 1'b0;
         M_ADDRESS   <= '0;
         M_WRITEDATA <= '0;
         I_READDATA  <= '0;
         D_READDATA  <= '0;
         ERR         <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant_c) begin
            owner_q <= grant_owner_c;
            last_q  <= grant_owner_c;
            if (grant_owner_c == OWN_D) begin
               // Read and write together resolve to a write.
               write_q     <= D_WRITE;
               M_READ      <= ~D_WRITE;
               M_WRITE     <= D_WRITE;
               M_ADDRESS   <= D_ADDRESS;
               M_WRITEDATA <= D_WRITEDATA;
            end else begin
               write_q   <= 1'b0;
               M_READ    <= 1'b1;
               M_WRITE   <= 1'b0;
               M_ADDRESS <= I_ADDRESS;
            end
         end
         if (finish_c) begin
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
         end
         if (capture_c) begin
            if (owner_q == OWN_D) begin
               D_READDATA <= M_READDATA;
            end else begin
               I_READDATA <= M_READDATA;
            end
         end
         if (timeout_c) begin
            ERR <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level round-robin/memory model.
module tb_mem_arbiter;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          I_READ = 1'b0;
   logic [AW-1:0] I_ADDRESS = '0;
   logic [DW-1:0] I_READDATA;
   logic          I_BUSYWAIT;
   logic          D_READ = 1'b0;
   logic          D_WRITE = 1'b0;
   logic [AW-1:0] D_ADDRESS = '0;
   logic [DW-1:0] D_WRITEDATA = '0;
   logic [DW-1:0] D_READDATA;
   logic          D_BUSYWAIT;
   logic          M_READ;
   logic          M_WRITE;
   logic [AW-1:0] M_ADDRESS;
   logic [DW-1:0] M_WRITEDATA;
   logic [DW-1:0] M_READDATA = '0;
   logic          M_BUSYWAIT = 1'b0;
   logic          ERR;

   mem_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .I_READ      (I_READ),
      .I_ADDRESS   (I_ADDRESS),
      .I_READDATA  (I_READDATA),
      .I_BUSYWAIT  (I_BUSYWAIT),
      .D_READ      (D_READ),
      .D_WRITE     (D_WRITE),
      .D_ADDRESS   (D_ADDRESS),
      .D_WRITEDATA (D_WRITEDATA),
      .D_READDATA  (D_READDATA),
      .D_BUSYWAIT  (D_BUSYWAIT),
      .M_READ      (M_READ),
      .M_WRITE     (M_WRITE),
      .M_ADDRESS   (M_ADDRESS),
      .M_WRITEDATA (M_WRITEDATA),
      .M_READDATA  (M_READDATA),
      .M_BUSYWAIT  (M_BUSYWAIT),
      .ERR         (ERR)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic          i_read;
      logic          d_read;
      logic          d_write;
      logic          m_busy;
      logic          m_read;
      logic          m_write;
      logic          i_bw;
      logic          d_bw;
      logic [AW-1:0] m_addr;
      logic [DW-1:0] i_rd;
   } vec_t;

   vec_t tbl [10];

   // Random-phase model state.
   logic [DW-1:0] mem [64];
   bit            i_act, d_act, inflight, exp_own, exp_wr, last_own;
   int            wj, lat, i_age, d_age, d_op;
   logic [AW-1:0] i_addr, d_addr;
   logic [DW-1:0] d_wd, exp_rd, i_rd_m, d_rd_m;
   logic [63:0]   act_bus, exp_bus;
   logic [3:0]    seq;
   int            n_done, cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input string nm, input bit is_d, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int busy_n,
                          input int exp_done, input bit exp_err, input logic [DW-1:0] exp_rdata);
      int            c = 0;
      int            w = -1;
      bit            done = 1'b0;
      bit            strobe_ok = 1'b1;
      bit            bw;
      logic          end_strobe = 1'b0;
      logic [AW-1:0] seen_addr = '0;
      logic [DW-1:0] seen_wd = '0;
      @(negedge CLK);
      M_READDATA = rd;
      if (is_d) begin
         D_ADDRESS   = addr;
         D_WRITEDATA = wd;
         D_READ      = ~wr;
         D_WRITE     = wr;
      end else begin
         I_ADDRESS = addr;
         I_READ    = 1'b1;
      end
      while (!done && c < 64) begin
         if (M_READ || M_WRITE) begin
            seen_addr  = M_ADDRESS;
            seen_wd    = M_WRITEDATA;
            M_BUSYWAIT = (w < 0) ? 1'b1 : (w < busy_n);
            w++;
         end else begin
            M_BUSYWAIT = 1'b0;
         end
         #1;
         bw = is_d ? D_BUSYWAIT : I_BUSYWAIT;
         if (!bw) begin
            done       = 1'b1;
            end_strobe = M_READ | M_WRITE;
         end else if (c >= 1) begin
            strobe_ok &= wr ? (M_WRITE && !M_READ) : (M_READ && !M_WRITE);
         end else begin
            strobe_ok &= !(M_READ || M_WRITE);
         end
         if (!done) begin
            @(negedge CLK);
            c++;
         end
      end
      check({nm, "_latency"}, 64'(c), 64'(exp_done));
      check({nm, "_strobes"}, 64'({strobe_ok, end_strobe}), 64'(2'b10));
      check({nm, "_addr"}, 64'(seen_addr), 64'(addr));
      if (wr) check({nm, "_wdata"}, 64'(seen_wd), 64'(wd));
      check({nm, "_rdata"}, 64'(is_d ? D_READDATA : I_READDATA), 64'(exp_rdata));
      check({nm, "_err"}, 64'(ERR), 64'(exp_err));
      I_READ  = 1'b0;
      D_READ  = 1'b0;
      D_WRITE = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      //       iR dR dW mB | mR mW iBW dBW  addr   I_READDATA
      tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 32'h0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'h02, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'h02, 32'h0};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h02, 32'h0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h02, 32'h0};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h02, 32'h0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h01, 32'h0};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h01, 32'h0};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 32'hCAFE0001};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 32'hCAFE0001};

      // Reset values.
      repeat (2) @(negedge CLK);
      #1;
      check("reset_bus", {M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA, 24'h0}, 64'h0);
      check("reset_rdata", {I_READDATA, D_READDATA}, 64'h0);
      check("reset_err", 64'(ERR), 64'h0);
      @(negedge CLK);
      RESET = 1'b1;

      // Conflict: D write served first, then I read.
      I_ADDRESS   = 6'h01;
      D_ADDRESS   = 6'h02;
      D_WRITEDATA = 32'h12345678;
      M_READDATA  = 32'hCAFE0001;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         I_READ     = tbl[k].i_read;
         D_READ     = tbl[k].d_read;
         D_WRITE    = tbl[k].d_write;
         M_BUSYWAIT = tbl[k].m_busy;
         #1;
         check($sformatf("table_%0d", k),
               64'({M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT, M_ADDRESS, I_READDATA}),
               64'({tbl[k].m_read, tbl[k].m_write, tbl[k].i_bw, tbl[k].d_bw, tbl[k].m_addr, tbl[k].i_rd}));
         if (tbl[k].m_write) check($sformatf("table_%0d_wdata", k), 64'(M_WRITEDATA), 64'h12345678);
         check($sformatf("table_%0d_err", k), 64'({ERR, D_READDATA}), 64'h0);
      end

      // Reset in the middle of WAIT abandons the access.
      @(negedge CLK);
      I_READ     = 1'b1;
      M_BUSYWAIT = 1'b1;
      repeat (2) @(negedge CLK);
      #1;
      check("pre_reset_strobe", 64'({M_READ, M_WRITE}), 64'(2'b10));
      #2;
      RESET = 1'b0;
      #1;
      check("midwait_reset", 64'({M_READ, M_WRITE, ERR, I_BUSYWAIT}), 64'(4'b0001));
      check("midwait_reset_rdata", {I_READDATA, D_READDATA}, 64'h0);
      @(negedge CLK);
      I_READ     = 1'b0;
      M_BUSYWAIT = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;

      // Both hold requests: grants alternate starting with D.
      I_READ = 1'b1;
      D_READ = 1'b1;
      seq    = 4'h0;
      n_done = 0;
      cyc    = 0;
      while (n_done < 4 && cyc < 80) begin
         #1;
         if (!D_BUSYWAIT) begin
            seq = {seq[2:0], 1'b1};
            n_done++;
         end else if (!I_BUSYWAIT) begin
            seq = {seq[2:0], 1'b0};
            n_done++;
         end
         if (n_done == 4) begin
            I_READ = 1'b0;
            D_READ = 1'b0;
         end
         @(negedge CLK);
         cyc++;
      end
      check("alt_count", 64'(n_done), 64'd4);
      check("alt_order", 64'(seq), 64'(4'b1010));

      run_txn("dread_slow", 1'b1, 1'b0, 6'h0A, 32'h0, 32'hDEADBEEF, 5, 8, 1'b0, 32'hDEADBEEF);
      run_txn("iread_zero", 1'b0, 1'b0, 6'h03, 32'h0, 32'h5555AAAA, 0, 3, 1'b0, 32'h5555AAAA);
      run_txn("dread_tmo", 1'b1, 1'b0, 6'h04, 32'h0, 32'h0BADF00D, 1000, 2 + TO, 1'b1, 32'hDEADBEEF);
      run_txn("dwrite_post", 1'b1, 1'b1, 6'h05, 32'hA5A5A5A5, 32'h0, 1, 4, 1'b1, 32'hDEADBEEF);
      run_txn("iread_post", 1'b0, 1'b0, 6'h06, 32'h0, 32'h13572468, 2, 5, 1'b1, 32'h13572468);

      // ERR is cleared only by reset.
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      check("err_reset", 64'(ERR), 64'h0);
      @(negedge CLK);
      RESET = 1'b1;

      // Randomized traffic against the transaction-level model.
      for (int a = 0; a < 64; a++) mem[a] = $urandom;
      i_act = 1'b0; d_act = 1'b0; inflight = 1'b0; last_own = 1'b0;
      exp_own = 1'b0; exp_wr = 1'b0; exp_rd = '0;
      wj = -1; lat = 0; i_age = 0; d_age = 0; d_op = 0;
      i_addr = '0; d_addr = '0; d_wd = '0; i_rd_m = '0; d_rd_m = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         if (M_READ || M_WRITE) begin
            if (wj < 0) begin
               if (i_act && d_act) exp_own = ~last_own;
               else                exp_own = d_act;
               exp_wr = exp_own ? (d_op != 0) : 1'b0;
               if (!i_act && !d_act) exp_bus = '0;
               else if (exp_own)     exp_bus = {24'h0, ~exp_wr, exp_wr, d_addr, exp_wr ? d_wd : 32'h0};
               else                  exp_bus = {24'h0, 1'b1, 1'b0, i_addr, 32'h0};
               act_bus = {24'h0, M_READ, M_WRITE, M_ADDRESS, M_WRITE ? M_WRITEDATA : 32'h0};
               check("rnd_grant", act_bus, exp_bus);
               last_own   = exp_own;
               inflight   = 1'b1;
               exp_rd     = mem[exp_own ? d_addr : i_addr];
               lat        = $urandom_range(0, 4);
               wj         = 0;
               M_BUSYWAIT = 1'($urandom_range(0, 1));
            end else begin
               M_BUSYWAIT = (wj < lat);
               if (!M_BUSYWAIT && M_WRITE) mem[M_ADDRESS] = M_WRITEDATA;
               wj++;
            end
         end else begin
            wj         = -1;
            M_BUSYWAIT = 1'($urandom_range(0, 1));
         end
         M_READDATA = mem[M_ADDRESS];
         #1;
         check("rnd_idle", 64'({!i_act & I_BUSYWAIT, !d_act & D_BUSYWAIT, M_READ & M_WRITE, ERR}), 64'h0);
         if (i_act && !I_BUSYWAIT) begin
            if (inflight && !exp_own) i_rd_m = exp_rd;
            check("rnd_i_done", 64'({inflight, ~exp_own, M_READ | M_WRITE}), 64'(3'b110));
            check("rnd_i_data", 64'(I_READDATA), 64'(i_rd_m));
            i_act    = 1'b0;
            inflight = 1'b0;
         end
         if (d_act && !D_BUSYWAIT) begin
            if (inflight && exp_own && !exp_wr) d_rd_m = exp_rd;
            check("rnd_d_done", 64'({inflight, exp_own, M_READ | M_WRITE}), 64'(3'b110));
            check("rnd_d_data", 64'(D_READDATA), 64'(d_rd_m));
            d_act    = 1'b0;
            inflight = 1'b0;
         end
         if (i_act) i_age++;
         if (d_act) d_age++;
         if (i_age > 100) begin
            check("rnd_i_hang", 64'(i_age), 64'h0);
            i_act = 1'b0;
            i_age = 0;
         end
         if (d_age > 100) begin
            check("rnd_d_hang", 64'(d_age), 64'h0);
            d_act = 1'b0;
            d_age = 0;
         end
         if (!i_act && $urandom_range(0, 3) == 0) begin
            i_act  = 1'b1;
            i_age  = 0;
            i_addr = 6'($urandom);
         end
         if (!d_act && $urandom_range(0, 3) == 0) begin
            d_act  = 1'b1;
            d_age  = 0;
            d_addr = 6'($urandom);
            d_wd   = $urandom;
            d_op   = $urandom_range(0, 2);
         end
         I_READ      = i_act;
         I_ADDRESS   = i_addr;
         D_READ      = d_act && (d_op != 1);
         D_WRITE     = d_act && (d_op != 0);
         D_ADDRESS   = d_addr;
         D_WRITEDATA = d_wd;
      end

      I_READ  = 1'b0;
      D_READ  = 1'b0;
      D_WRITE = 1'b0;
      repeat (4) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one main-memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between both caches and the block-organised data memory. The CPU stalls on the per-requester busywait outputs.
- Arbitrates with round-robin on conflict. Sequences each access with a 4-state FSM.
- A watchdog counter aborts memory transactions that hang.

Parameters:
- ADDR_W, 6, block address width.
- DATA_W, 32, block data width.
- TIMEOUT, 255, maximum WAIT cycles before abort. Must be ≥2.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-low reset.
- I_READ  input  1  icache read request (level, held until I_BUSYWAIT low).
- I_ADDRESS  input  ADDR_W  icache block address.
- I_READDATA  output  DATA_W  block returned to icache (registered).
- I_BUSYWAIT  output  1  stall to icache.
- D_READ  input  1  dcache read request.
- D_WRITE  input  1  dcache write request.
- D_ADDRESS  input  ADDR_W  dcache block address.
- D_WRITEDATA  input  DATA_W  dcache write block.
- D_READDATA  output  DATA_W  block returned to dcache (registered).
- D_BUSYWAIT  output  1  stall to dcache.
- M_READ  output  1  memory read strobe.
- M_WRITE  output  1  memory write strobe.
- M_ADDRESS  output  ADDR_W  memory block address.
- M_WRITEDATA  output  DATA_W  memory write block.
- M_READDATA  input  DATA_W  memory read block.
- M_BUSYWAIT  input  1  memory busy; high while servicing.
- ERR  output  1  sticky timeout flag.

Behaviour:
- Reset (RESET=0, async):
  - State=IDLE.
  - M_READ=M_WRITE=0; M_ADDRESS, M_WRITEDATA=0.
  - I_READDATA, D_READDATA=0; ERR=0.
  - last_grant=I, so D wins the first conflict.
  - Watchdog count=0.
  - Reset mid-transaction abandons it with no completion.
- Pending: i_req=I_READ; d_req=D_READ|D_WRITE.
- D_READ and D_WRITE both high is treated as a write.
- Busywait (combinational):
  - X_BUSYWAIT = x_req & !(state==DONE & owner==X).
  - Busywait is 0 when that requester has no pending request.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay.
  - One pending: grant it.
  - Both pending: grant the one that is not last_grant.
  - On grant: latch owner, op (read/write), address, writedata; update last_grant; go ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive M_READ/M_WRITE per latched op; M_ADDRESS/M_WRITEDATA from latches.
  - Clear count. Go WAIT.
- WAIT:
  - Keep strobes asserted; count++ each cycle.
  - If M_BUSYWAIT==0 at posedge:
    - Read: capture M_READDATA into the owner's READDATA register.
    - Drop strobes. Go DONE.
  - Else if count==TIMEOUT-1:
    - Set ERR=1; drop strobes. Go DONE.
    - READDATA is unchanged.
- DONE (exactly 1 cycle):
  - Owner's busywait is low.
  - Next cycle go IDLE; re-arbitration happens there.
  - A requester still asserting a request in IDLE is treated as a new request.
- Latency with zero-wait memory: request seen at edge 0, ISSUE at 1, WAIT at 2, DONE at 3. Busywait falls during cycle 3.
- Request withdrawn mid-transaction: the transaction completes on the latched values; the result is still written to READDATA.
- The non-owner stays stalled throughout. Requests arriving in ISSUE/WAIT/DONE are only considered in IDLE.
- Strobes are never asserted in IDLE or DONE. At most one of M_READ/M_WRITE is high.
- ERR clears only on reset.

Decomposition:
- Shared package: state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3) and owner encoding (I=0, D=1), plus ADDR_W/DATA_W defaults shared with cache and memory modules.
- One natural sub-module, mem_watchdog: loadable counter with clear, enable, and a terminal-count flag at TIMEOUT-1.

Test Plan:
- RESET low mid-WAIT → strobes 0 immediately, both READDATA=0, ERR=0; after release, D_READ=1 → D granted first.
- D_READ=1, D_ADDRESS=6'h0A; memory busy for 5 cycles then returns 32'hDEADBEEF → M_READ high from ISSUE through the WAIT edge where M_BUSYWAIT=0; D_READDATA=32'hDEADBEEF; D_BUSYWAIT low for 1 cycle in DONE.
- I_READ and D_WRITE raised in the same cycle (addr 6'h01 / 6'h02, data 32'h12345678) → D served first (M_WRITE, M_ADDRESS=6'h02, M_WRITEDATA=32'h12345678); then I served (M_READ, M_ADDRESS=6'h01); I_BUSYWAIT high throughout D's access.
- Both requesters re-assert continuously for 4 transactions → grants alternate D, I, D, I.
- Zero-wait memory (M_BUSYWAIT never high) → busywait falls 3 cycles after the request edge; captured data equals M_READDATA.
- M_BUSYWAIT stuck high, TIMEOUT=8 → after 8 WAIT cycles ERR=1, strobes drop, owner busywait low for 1 cycle, READDATA unchanged.
